usb_crc_stuff_tx: RTL and testbench
===================================

Name: usb_crc_stuff_tx

Overview:
- Parametrised USB transmit serialiser for the USB controller TX path.
- Takes a whole packet in parallel (PID plus body), shifts it out LSB-first and appends a complemented CRC5 or CRC16 in the selected mode.
- Inserts bit-stuff zeros inline under a ready/valid bit handshake toward the NRZI encoder.
- Merges packet serialisation, CRC generation and stuffing into one block with backpressure, CRC16 support and length checking.

Parameters:
- MAX_BITS, 100: width of pkt_data; maximum accepted pkt_len.
- PID_BITS, 8: leading bits excluded from the CRC.
- STUFF_RUN, 6: consecutive transmitted ones that force a stuffed 0.
- STUFF_PID, 0: 1 = PID bits count toward the ones run; 0 = run counting starts after the PID.
- LEN_W, $clog2(MAX_BITS+1): width of pkt_len.

Ports:
- clock  in  1  rising-edge clock.
- reset  in  1  synchronous, active-high reset.
- pkt_valid  in  1  packet offered.
- pkt_ready  out  1  block idle, can accept a packet.
- pkt_data  in  MAX_BITS  packet bits; bit 0 is transmitted first.
- pkt_len  in  LEN_W  total PID plus body bits, CRC excluded.
- crc_mode  in  2  0 none, 1 CRC5, 2 CRC16, 3 illegal.
- out_ready  in  1  downstream consumes out_bit this cycle.
- out_valid  out  1  out_bit is valid.
- out_bit  out  1  serial bit.
- out_last  out  1  out_bit is the final bit of the packet.
- err  out  1  one-cycle pulse: packet rejected.

Behaviour:
- Ports and reset:
  - One clock; reset is synchronous and active-high.
  - Reset values: pkt_ready=0 during reset, 1 the cycle after; out_valid=0, out_bit=0, out_last=0, err=0.
  - All counters are cleared and the CRC register is set to all ones.
- Accept:
  - A packet is accepted on pkt_valid & pkt_ready.
  - pkt_data, pkt_len and crc_mode are latched on acceptance; later input changes are ignored.
  - pkt_ready is 1 only in IDLE.
- Reject:
  - Trigger: pkt_len < PID_BITS, pkt_len > MAX_BITS, or crc_mode==3.
  - Response: err=1 the following cycle, no bits emitted, remain in IDLE.
- Latency:
  - First out_valid occurs the cycle after acceptance.
  - A bit transfers when out_valid & out_ready.
  - out_bit and out_last hold stable while out_valid & ~out_ready.
- FSM states: IDLE, PID, BODY, CRC, STUFF.
  - IDLE -> PID on a legal accept.
  - PID -> BODY after PID_BITS transfers.
  - If pkt_len==PID_BITS, PID goes straight to CRC, or to done when mode 0.
  - BODY -> CRC after pkt_len transfers total, or to done in mode 0.
  - CRC -> done after 5 (CRC5) or 16 (CRC16) transfers.
  - Any state -> STUFF when the transferred bit completes a run of STUFF_RUN ones.
  - STUFF offers out_bit=0 without advancing the source, then returns to the interrupted state, or to IDLE if that was the final bit.
  - done -> IDLE.
- CRC:
  - CRC5 polynomial x^5+x^2+1; CRC16 polynomial x^16+x^15+x^2+1.
  - The register is initialised to all ones at accept.
  - It updates only on transfer of body bits; PID and stuff bits are excluded.
  - CRC bits are emitted complemented, highest register bit first.
- Stuffing:
  - The ones counter increments on each transferred 1 and clears on each transferred 0, including stuff bits.
  - It is active over body and CRC bits, plus PID bits when STUFF_PID=1.
  - If the final data or CRC bit completes a run, the stuff 0 is still sent and carries out_last.
- out_last is high only on the last bit offered for the packet.
- A reset mid-packet aborts the packet:
  - next cycle out_valid=0, IDLE;
  - no err pulse;
  - partial packet discarded.

Test Plan:
- Token, mode 1, pkt_len=19, PID 0xE1, addr 0, endp 0, out_ready=1 -> 24 bits: 1,0,0,0,0,1,1,1, then 11 zeros, then 0,1,0,0,0; out_last on bit 24; pkt_ready back at 1 the next cycle.
- Zero-length DATA0, PID 0xC3, pkt_len=8, mode 2 -> 1,1,0,0,0,0,1,1 followed by 16 zeros, 24 bits total.
- Stuffing, mode 0:
  - PID 0xC3, body 0xFF, pkt_len=16 -> 17 bits; body portion 1,1,1,1,1,1,0,1,1.
  - pkt_len=14, body 6'b111111 -> 15 bits, stuffed 0 last with out_last=1.
- Backpressure: drop out_ready for 3 cycles at bit 10 of the token test -> out_bit and out_valid held constant; full sequence otherwise identical.
- Illegal input:
  - crc_mode=3 -> err=1 for exactly one cycle, out_valid stays 0.
  - pkt_len=5 -> err=1 for exactly one cycle, out_valid stays 0.
  - pkt_len=MAX_BITS+1 -> err=1 for exactly one cycle, out_valid stays 0.
- Reset asserted at bit 12 of the token test -> out_valid=0 next cycle, no err. A following fresh token then produces the exact 24-bit sequence from the first test.

Source files
------------

// File: rtl/usb_crc_stuff_tx_if.sv
// Packet-in / serial-bit-out bundle between the USB TX packet source, this
// serialiser and the NRZI encoder.
interface usb_crc_stuff_tx_if #(
  parameter int MAX_BITS = 100,
  parameter int LEN_W    = $clog2(MAX_BITS + 1)
);
  // Both sides use plain valid/ready: a packet (or a bit) moves on the cycle
  // where valid & ready are both high; the offered payload holds until then.
  logic                pkt_valid;
  logic                pkt_ready;
  logic [MAX_BITS-1:0] pkt_data;
  logic [LEN_W-1:0]    pkt_len;
  logic [1:0]          crc_mode;
  logic                out_ready;
  logic                out_valid;
  logic                out_bit;
  logic                out_last;
  logic                err;

  modport slave (
    input  pkt_valid, pkt_data, pkt_len, crc_mode, out_ready,
    output pkt_ready, out_valid, out_bit, out_last, err
  );

  modport master (
    output pkt_valid, pkt_data, pkt_len, crc_mode, out_ready,
    input  pkt_ready, out_valid, out_bit, out_last, err
  );
endinterface

// File: rtl/usb_crc_stuff_tx.sv
// USB TX serialiser: shifts a parallel packet out LSB-first, appends the
// complemented CRC5/CRC16 and inserts bit-stuff zeros under backpressure.
module usb_crc_stuff_tx #(
  parameter int MAX_BITS  = 100,
  parameter int PID_BITS  = 8,
  parameter int STUFF_RUN = 6,
  parameter int STUFF_PID = 0,
  parameter int LEN_W     = $clog2(MAX_BITS + 1)
) (
  input  logic               clock,
  input  logic               reset,
  usb_crc_stuff_tx_if.slave  bus,
  output logic [2:0]         dbg_state_o
);
  localparam int RUN_W = $clog2(STUFF_RUN + 1);

  typedef enum logic [2:0] {S_IDLE, S_PID, S_BODY, S_CRC, S_STUFF} state_e;

  state_e              state_q, state_d, ret_q, ret_d, after_st;
  logic [MAX_BITS-1:0] data_q, data_d;
  logic [LEN_W-1:0]    len_q, len_d, idx_q, idx_d, idx_inc;
  logic [1:0]          mode_q, mode_d;
  logic [15:0]         crc_q, crc_d;
  logic [4:0]          crc_cnt_q, crc_cnt_d, crc_inc, crc_len;
  logic [RUN_W-1:0]    ones_q, ones_d;
  logic                stuff_last_q, stuff_last_d;
  logic                ready_q, err_q, err_d;
  logic                accept, legal, out_valid, out_bit, out_last, xfer;
  logic                count_en, stuff_now, src_final, fb5, fb16;

  assign accept    = bus.pkt_valid & ready_q;
  assign legal     = (bus.pkt_len >= LEN_W'(PID_BITS)) &&
                     (bus.pkt_len <= LEN_W'(MAX_BITS)) && (bus.crc_mode != 2'd3);
  assign out_valid = (state_q != S_IDLE);
  assign xfer      = out_valid & bus.out_ready;
  assign count_en  = (state_q != S_PID) || (STUFF_PID != 0);
  assign idx_inc   = idx_q + 1'b1;
  assign crc_inc   = crc_cnt_q + 5'd1;
  assign crc_len   = (mode_q == 2'd1) ? 5'd5 : 5'd16;
  assign fb5       = data_q[0] ^ crc_q[4];
  assign fb16      = data_q[0] ^ crc_q[15];

  // Decode the bit on offer and where the source goes after it transfers.
  always_comb begin
    out_bit   = 1'b0;
    after_st  = state_q;
    src_final = 1'b0;
    case (state_q)
      S_PID: begin
        out_bit = data_q[0];
        if (idx_inc == LEN_W'(PID_BITS)) begin
          if (len_q != LEN_W'(PID_BITS)) after_st = S_BODY;
          else if (mode_q == 2'd0)       src_final = 1'b1;
          else                           after_st = S_CRC;
        end
      end
      S_BODY: begin
        out_bit = data_q[0];
        if (idx_inc == len_q) begin
          if (mode_q == 2'd0) src_final = 1'b1;
          else                after_st = S_CRC;
        end
      end
      S_CRC: begin
        out_bit = (mode_q == 2'd1) ? ~crc_q[4] : ~crc_q[15];
        if (crc_inc == crc_len) src_final = 1'b1;
      end
      default: ;
    endcase
  end

  assign stuff_now = (state_q inside {S_PID, S_BODY, S_CRC}) && count_en && out_bit &&
                     (ones_q == RUN_W'(STUFF_RUN - 1));
  // A trailing stuff zero inherits out_last from the data/CRC bit it follows.
  assign out_last  = (state_q == S_STUFF) ? stuff_last_q : (src_final & ~stuff_now);

  always_comb begin
    state_d      = state_q;
    ret_d        = ret_q;
    data_d       = data_q;
    len_d        = len_q;
    mode_d       = mode_q;
    idx_d        = idx_q;
    crc_d        = crc_q;
    crc_cnt_d    = crc_cnt_q;
    ones_d       = ones_q;
    stuff_last_d = stuff_last_q;
    err_d        = 1'b0;
    if (accept) begin
      if (legal) begin
        state_d      = S_PID;
        data_d       = bus.pkt_data;
        len_d        = bus.pkt_len;
        mode_d       = bus.crc_mode;
        idx_d        = '0;
        crc_d        = '1;
        crc_cnt_d    = '0;
        ones_d       = '0;
        stuff_last_d = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end else if (xfer) begin
      if (state_q == S_STUFF) begin
        state_d = ret_q;
        ones_d  = '0;
      end else begin
        if (count_en) ones_d = out_bit ? ones_q + 1'b1 : '0;
        if (state_q == S_PID || state_q == S_BODY) begin
          data_d = data_q >> 1;
          idx_d  = idx_inc;
        end
        if (state_q == S_BODY) begin
          if (mode_q == 2'd1) crc_d[4:0] = {crc_q[3:0], 1'b0} ^ (fb5 ? 5'h05 : 5'h00);
          else                crc_d = {crc_q[14:0], 1'b0} ^ (fb16 ? 16'h8005 : 16'h0000);
        end
        if (state_q == S_CRC) begin
          crc_d     = {crc_q[14:0], 1'b0};
          crc_cnt_d = crc_inc;
        end
        if (stuff_now) begin
          state_d      = S_STUFF;
          ret_d        = src_final ? S_IDLE : after_st;
          stuff_last_d = src_final;
        end else begin
          state_d = src_final ? S_IDLE : after_st;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      ret_q        <= S_IDLE;
      data_q       <= '0;
      len_q        <= '0;
      mode_q       <= '0;
      idx_q        <= '0;
      crc_q        <= '1;
      crc_cnt_q    <= '0;
      ones_q       <= '0;
      stuff_last_q <= 1'b0;
      ready_q      <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      ret_q        <= ret_d;
      data_q       <= data_d;
      len_q        <= len_d;
      mode_q       <= mode_d;
      idx_q        <= idx_d;
      crc_q        <= crc_d;
      crc_cnt_q    <= crc_cnt_d;
      ones_q       <= ones_d;
      stuff_last_q <= stuff_last_d;
      ready_q      <= (state_d == S_IDLE);
      err_q        <= err_d;
    end
  end

  assign bus.pkt_ready = ready_q;
  assign bus.out_valid = out_valid;
  assign bus.out_bit   = out_bit;
  assign bus.out_last  = out_last;
  assign bus.err       = err_q;
  assign dbg_state_o   = state_q;
endmodule

// File: tb/tb_usb_crc_stuff_tx.sv
// Directed bench for usb_crc_stuff_tx: token/data/stuffing packets,
// backpressure, rejects and mid-packet reset against hand-derived bit streams.
module tb_usb_crc_stuff_tx;
  localparam int MAX_BITS = 100;
  localparam int LEN_W    = $clog2(MAX_BITS + 1);

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] dbg_state;
  int         n_checks = 0;
  int         n_errors = 0;

  logic [0:0] exp_q[$];
  logic [0:0] got_q[$];
  logic [0:0] got_last_q[$];

  usb_crc_stuff_tx_if #(.MAX_BITS(MAX_BITS), .LEN_W(LEN_W)) bus ();

  usb_crc_stuff_tx #(
    .MAX_BITS(MAX_BITS), .PID_BITS(8), .STUFF_RUN(6), .STUFF_PID(0), .LEN_W(LEN_W)
  ) dut (
    .clock(clock), .reset(reset), .bus(bus), .dbg_state_o(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_checks++;
    assert (obs === exp_v) else begin
      n_errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
    end
  endtask

  task automatic load_exp(input string s);
    exp_q.delete();
    for (int i = 0; i < s.len(); i++) begin
      if (s[i] == 8'h31)      exp_q.push_back(1'b1);
      else if (s[i] == 8'h30) exp_q.push_back(1'b0);
    end
  endtask

  // driver: offer one packet for one cycle, then scramble the inputs
  task automatic send(input string name, input logic [MAX_BITS-1:0] data,
                      input logic [LEN_W-1:0] len, input logic [1:0] mode);
    check({name, " ready_in"}, bus.pkt_ready, 1);
    bus.pkt_valid = 1'b1;
    bus.pkt_data  = data;
    bus.pkt_len   = len;
    bus.crc_mode  = mode;
    tick();
    bus.pkt_valid = 1'b0;
    bus.pkt_data  = MAX_BITS'({$urandom, $urandom, $urandom, $urandom});
    bus.pkt_len   = LEN_W'($urandom_range(0, 100));
    bus.crc_mode  = 2'($urandom_range(0, 3));
  endtask

  task automatic collect(input string name, input int stall_at, input int stall_len,
                         input int abort_at);
    int   cycles;
    int   stalled;
    logic done;
    cycles  = 0;
    stalled = 0;
    done    = 1'b0;
    got_q.delete();
    got_last_q.delete();
    check({name, " first_lat"}, bus.out_valid, 1);
    check({name, " busy_ready"}, bus.pkt_ready, 0);
    while (!done && cycles < 300) begin
      if (abort_at >= 0 && got_q.size() == abort_at) begin
        reset = 1'b1;
        tick();
        check({name, " abort_valid"}, bus.out_valid, 0);
        check({name, " abort_err"}, bus.err, 0);
        reset = 1'b0;
        tick();
        check({name, " abort_ready"}, bus.pkt_ready, 1);
        check({name, " abort_err2"}, bus.err, 0);
        return;
      end
      if (bus.out_valid && got_q.size() == stall_at && stalled == 0) begin
        bus.out_ready = 1'b0;
        for (int k = 0; k < stall_len; k++) begin
          tick();
          check($sformatf("%s stall%0d_valid", name, k), bus.out_valid, 1);
          check($sformatf("%s stall%0d_bit", name, k), bus.out_bit, exp_q[stall_at]);
          check($sformatf("%s stall%0d_last", name, k), bus.out_last, 0);
        end
        bus.out_ready = 1'b1;
        stalled = 1;
      end
      if (bus.out_valid) begin
        got_q.push_back(bus.out_bit);
        got_last_q.push_back(bus.out_last);
        if (bus.out_last) done = 1'b1;
      end
      tick();
      cycles++;
    end
    check({name, " done"}, done, 1);
    check({name, " ready_after"}, bus.pkt_ready, 1);
    check({name, " valid_after"}, bus.out_valid, 0);
  endtask

  // scoreboard compare of collected stream against exp_q
  task automatic compare(input string name);
    check({name, " nbits"}, got_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < got_q.size(); i++) begin
      check($sformatf("%s bit%0d", name, i), got_q[i], exp_q[i]);
      check($sformatf("%s last%0d", name, i), got_last_q[i], (i == exp_q.size() - 1));
    end
  endtask

  task automatic reject(input string name, input logic [LEN_W-1:0] len, input logic [1:0] mode);
    send(name, MAX_BITS'(100'hE1), len, mode);
    check({name, " err"}, bus.err, 1);
    check({name, " valid"}, bus.out_valid, 0);
    check({name, " idle"}, bus.pkt_ready, 1);
    tick();
    check({name, " err_clr"}, bus.err, 0);
    check({name, " valid2"}, bus.out_valid, 0);
  endtask

  initial begin
    bus.pkt_valid = 1'b0;
    bus.pkt_data  = '0;
    bus.pkt_len   = '0;
    bus.crc_mode  = '0;
    bus.out_ready = 1'b1;
    tick();
    tick();
    check("rst ready", bus.pkt_ready, 0);
    check("rst valid", bus.out_valid, 0);
    check("rst bit", bus.out_bit, 0);
    check("rst last", bus.out_last, 0);
    check("rst err", bus.err, 0);
    check("rst state", dbg_state, 0);
    reset = 1'b0;
    tick();
    check("rst ready_after", bus.pkt_ready, 1);

    load_exp("10000111_00000000000_01000");
    send("tok", MAX_BITS'(100'hE1), LEN_W'(19), 2'd1);
    collect("tok", -1, 0, -1);
    compare("tok");

    load_exp("11000011_0000000000000000");
    send("data0", MAX_BITS'(100'hC3), LEN_W'(8), 2'd2);
    collect("data0", -1, 0, -1);
    compare("data0");

    load_exp("11000011_111111011");
    send("stuff16", MAX_BITS'(100'hFFC3), LEN_W'(16), 2'd0);
    collect("stuff16", -1, 0, -1);
    compare("stuff16");

    load_exp("11000011_1111110");
    send("stuff14", MAX_BITS'(100'h3FC3), LEN_W'(14), 2'd0);
    collect("stuff14", -1, 0, -1);
    compare("stuff14");

    load_exp("10000111_00000000000_01000");
    send("bp", MAX_BITS'(100'hE1), LEN_W'(19), 2'd1);
    collect("bp", 10, 3, -1);
    compare("bp");

    reject("rej_mode3", LEN_W'(19), 2'd3);
    reject("rej_len5", LEN_W'(5), 2'd1);
    reject("rej_len101", LEN_W'(MAX_BITS + 1), 2'd0);

    send("abort", MAX_BITS'(100'hE1), LEN_W'(19), 2'd1);
    collect("abort", -1, 0, 12);
    load_exp("10000111_00000000000_01000");
    send("tok2", MAX_BITS'(100'hE1), LEN_W'(19), 2'd1);
    collect("tok2", -1, 0, -1);
    compare("tok2");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule
